// File: rtl/bin2bcd_converter.sv
// ============================================================================
// Module     : bin2bcd_converter
// Description: Sequential 16-bit binary to 5-digit packed BCD converter
//              using the shift-add-3 (double-dabble) algorithm.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int          C_DIGITS   = 5;
  localparam logic [3:0]  C_LAST_ITER = 4'd15;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_bin_work;
  logic [19:0] r_bcd_work;
  logic [3:0]  r_count;
  logic [19:0] r_bcd;

  logic [19:0] w_adj;
  logic [19:0] w_bcd_shift;
  logic [15:0] w_bin_shift;
  logic        w_last;
  logic        w_unused_msb;

  // Digit correction happens on all five digits in parallel before the shift.
  generate
    for (genvar i = 0; i < C_DIGITS; i++) begin : g_digit
      assign w_adj[4*i +: 4] = (r_bcd_work[4*i +: 4] >= 4'd5) ?
                               (r_bcd_work[4*i +: 4] + 4'd3) :
                                r_bcd_work[4*i +: 4];
    end
  endgenerate

  assign w_bcd_shift  = {w_adj[18:0], r_bin_work[15]};
  assign w_bin_shift  = {r_bin_work[14:0], 1'b0};
  // The top digit never exceeds 3 before the final shift, so its MSB is always zero.
  assign w_unused_msb = w_adj[19];
  assign w_last       = (r_count == C_LAST_ITER);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CONV;
      S_CONV:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_work <= 16'h0000;
      r_bcd_work <= 20'h00000;
      r_count    <= 4'd0;
      r_bcd      <= 20'h00000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin_work <= bin;
            r_bcd_work <= 20'h00000;
            r_count    <= 4'd0;
          end
        end
        S_CONV: begin
          r_bin_work <= w_bin_shift;
          r_bcd_work <= w_bcd_shift;
          r_count    <= r_count + 4'd1;
          // Only the completed result is ever published on bcd.
          if (w_last) begin
            r_bcd <= w_bcd_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd  = r_bcd;
  assign busy = (r_state == S_CONV);
  assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_converter.sv
// ============================================================================
// Module     : tb_bin2bcd_converter
// Description: Self-checking bench for bin2bcd_converter (vectors, random,
//              abort, back-to-back and ignored-start sequences).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  bin2bcd_converter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one conversion, scramble bin afterwards, check latency/busy/result.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] exp, input string name);
    int k;
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      bin   = ~v;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_n++;
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, " latency"}, 32'(k - 1), 32'd16);
      chk({name, " busy_cycles"}, 32'(busy_n), 32'd16);
      chk({name, " bcd"}, 32'(bcd), 32'(exp));
      @(negedge clk);
      chk({name, " done_width"}, 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[$];
  logic [19:0] held;
  int dones;
  int t1, t2;
  logic [19:0] cap;

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    bin   = 16'd1234;
    vecs = '{
      '{16'd0,     20'h00000},
      '{16'd255,   20'h00255},
      '{16'd25527, 20'h25527},
      '{16'd65025, 20'h65025},
      '{16'd65535, 20'h65535},
      '{16'd1,     20'h00001},
      '{16'd9999,  20'h09999},
      '{16'd10000, 20'h10000},
      '{16'd59999, 20'h59999}
    };

    // start held high during reset must not launch anything
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bcd", 32'(bcd), 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

    // idle with start low keeps outputs stable
    held = bcd;
    repeat (4) @(negedge clk);
    chk("idle bcd hold", 32'(bcd), 32'(held));
    chk("idle busy", 32'(busy), 32'd0);

    run_conv(16'(170 * 170), 20'h28900, "chain170x170");

    for (int r = 0; r < 16; r++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      run_conv(v, ref_bcd(v), $sformatf("rand%0d_%0d", r, v));
    end

    // second start mid-conversion is ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd300;
    @(posedge clk);
    dones = 0;
    cap   = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        bin   = 16'd2500;
        start = 1'b1;
      end
      if (done) begin
        dones++;
        cap = bcd;
      end
    end
    start = 1'b0;
    chk("ignored_start dones", 32'(dones), 32'd1);
    chk("ignored_start bcd", 32'(cap), 32'h00300);

    // reset mid-conversion aborts it
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd16384;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    chk("abort bcd_after", 32'(bcd), 32'd0);
    run_conv(16'd28900, 20'h28900, "after_abort");

    // start held high: back-to-back conversions every 18 cycles
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd256;
    dones = 0;
    t1 = 0;
    t2 = 0;
    for (int c = 1; c <= 60 && dones < 2; c++) begin
      @(negedge clk);
      if (dones == 1 && c == t1 + 9) chk("b2b bcd_hold", 32'(bcd), 32'h00256);
      if (done) begin
        dones++;
        if (dones == 1) begin
          t1 = c;
          chk("b2b first bcd", 32'(bcd), 32'h00256);
          bin = 16'd65025;
        end else begin
          t2 = c;
          chk("b2b second bcd", 32'(bcd), 32'h65025);
        end
      end
    end
    start = 1'b0;
    chk("b2b done_count", 32'(dones), 32'd2);
    chk("b2b spacing", 32'(t2 - t1), 32'd18);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
